// File: rtl/des_iterative_core.sv
// Iterative DES core: IP, 16 Feistel rounds (ROUNDS_PER_CYCLE unrolled per clock), FP.
// Optional feature macro DES_DECRYPT_EN enables the decrypt input and right-rotating key schedule.
module des_iterative_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [1:64] data_in,
    input  logic [1:64] key_in,
    output logic        busy,
    output logic        done,
    output logic [1:64] data_out
);
    localparam int RPC = ROUNDS_PER_CYCLE;

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_param
        $error("des_iterative_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    // Each S box is 64 nibbles in row-major order (row = outer bits, column = inner four).
    localparam logic [0:63][3:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [1:0] enc_shift(input logic [4:0] n);
        return (n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [1:28] rotl(input logic [1:28] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[2:28], x[1]};
            2'd2:    return {x[3:28], x[1:2]};
            default: return x;
        endcase
    endfunction

`ifdef DES_DECRYPT_EN
    // Decrypt walks the schedule backwards: no shift before round 1 yields K16 directly.
    function automatic logic [1:0] dec_shift(input logic [4:0] n);
        if (n == 5'd1)
            return 2'd0;
        return (n == 5'd2 || n == 5'd9 || n == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [1:28] rotr(input logic [1:28] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[28], x[1:27]};
            2'd2:    return {x[27:28], x[1:26]};
            default: return x;
        endcase
    endfunction
`endif

    typedef enum logic {IDLE, ROUND} state_t;

    state_t      state_reg, state_next;
    logic        load, finish;
    logic [4:0]  cnt_reg, cnt_sum;
    logic [1:32] l_reg, r_reg;
    logic [1:28] c_reg, d_reg;
    logic        done_reg;
    logic [1:64] out_reg;
    logic [1:64] ip_v, pre_out, fp_v;
    logic [1:56] pc1_v;
    logic [1:32] l_last, r_last;
    logic [1:28] c_last, d_last;
    logic        unused_inputs;

`ifdef DES_DECRYPT_EN
    logic        mode_reg;
    assign unused_inputs = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                             key_in[40], key_in[48], key_in[56], key_in[64]};
`else
    assign unused_inputs = ^{decrypt, key_in[8], key_in[16], key_in[24], key_in[32],
                             key_in[40], key_in[48], key_in[56], key_in[64]};
`endif

    genvar gi, gj;

    for (gi = 0; gi < 64; gi++) begin : g_ip_fp
        assign ip_v[gi+1] = data_in[IP_T[gi]];
        assign fp_v[gi+1] = pre_out[FP_T[gi]];
    end

    for (gi = 0; gi < 56; gi++) begin : g_pc1
        assign pc1_v[gi+1] = key_in[PC1_T[gi]];
    end

    for (gi = 0; gi < RPC; gi++) begin : g_round
        logic [4:0]  rnd;
        logic [1:32] l_in, r_in, l_out, r_out, s_out, f_out;
        logic [1:28] c_in, d_in, c_rot, d_rot;
        logic [1:56] cd_rot;
        logic [1:48] subkey, e_out, s_in;

        if (gi == 0) begin : g_first
            assign l_in = l_reg;
            assign r_in = r_reg;
            assign c_in = c_reg;
            assign d_in = d_reg;
        end else begin : g_chain
            assign l_in = g_round[gi-1].l_out;
            assign r_in = g_round[gi-1].r_out;
            assign c_in = g_round[gi-1].c_rot;
            assign d_in = g_round[gi-1].d_rot;
        end

        assign rnd = cnt_reg + 5'(gi + 1);

        always_comb begin
            c_rot = rotl(c_in, enc_shift(rnd));
            d_rot = rotl(d_in, enc_shift(rnd));
`ifdef DES_DECRYPT_EN
            if (mode_reg) begin
                c_rot = rotr(c_in, dec_shift(rnd));
                d_rot = rotr(d_in, dec_shift(rnd));
            end
`endif
        end

        assign cd_rot = {c_rot, d_rot};

        for (gj = 0; gj < 48; gj++) begin : g_pc2_e
            assign subkey[gj+1] = cd_rot[PC2_T[gj]];
            assign e_out[gj+1]  = r_in[((gj / 6) * 4 + gj % 6 + 31) % 32 + 1];
        end

        assign s_in = e_out ^ subkey;

        for (gj = 0; gj < 8; gj++) begin : g_sbox
            logic [5:0] six;
            assign six = s_in[6*gj+1 +: 6];
            assign s_out[4*gj+1 +: 4] = SBOX[gj][{six[5], six[0], six[4:1]}];
        end

        for (gj = 0; gj < 32; gj++) begin : g_p
            assign f_out[gj+1] = s_out[P_T[gj]];
        end

        assign l_out = r_in;
        assign r_out = l_in ^ f_out;
    end

    assign l_last  = g_round[RPC-1].l_out;
    assign r_last  = g_round[RPC-1].r_out;
    assign c_last  = g_round[RPC-1].c_rot;
    assign d_last  = g_round[RPC-1].d_rot;
    assign pre_out = {r_last, l_last};
    assign cnt_sum = cnt_reg + 5'(RPC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ROUND;
                    load       = 1'b1;
                end
            end
            ROUND: begin
                if (cnt_sum == 5'd16) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_reg    <= '0;
            r_reg    <= '0;
            c_reg    <= '0;
            d_reg    <= '0;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
            out_reg  <= '0;
`ifdef DES_DECRYPT_EN
            mode_reg <= 1'b0;
`endif
        end else begin
            done_reg <= finish;
            if (load) begin
                l_reg    <= ip_v[1:32];
                r_reg    <= ip_v[33:64];
                c_reg    <= pc1_v[1:28];
                d_reg    <= pc1_v[29:56];
                cnt_reg  <= '0;
`ifdef DES_DECRYPT_EN
                mode_reg <= decrypt;
`endif
            end else if (state_reg == ROUND) begin
                l_reg   <= l_last;
                r_reg   <= r_last;
                c_reg   <= c_last;
                d_reg   <= d_last;
                cnt_reg <= finish ? 5'd0 : cnt_sum;
            end
            if (finish)
                out_reg <= fp_v;
        end
    end

    assign busy     = (state_reg == ROUND);
    assign done     = done_reg;
    assign data_out = out_reg;

endmodule
